ddr_burst_responder: RTL and testbench

DDR_BURST_RESPONDER -- requirements
Module: ddr_burst_responder

---
 rtl/ddr_pkg.sv | 22 ++
 rtl/ddr_byte_ram.sv | 26 ++
 rtl/ddr_burst_responder.sv | 217 +++++++++++++++++++++
 tb/tb_ddr_burst_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR burst responder.
package ddr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWriteBurst,
    StReadWait,
    StReadBurst
  } ddr_state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned ReadLatencyMin = 2;
  localparam int unsigned ReadLatencyMax = 15;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/ddr_byte_ram.sv
// 64-bit single-port RAM with per-byte write enables and a registered read port.
module ddr_byte_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [7:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o
);

  logic [63:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/ddr_burst_responder.sv
// Burst-capable DDR-style memory responder with fixed read latency.
// Optional random backpressure in IDLE/WRITE_BURST under DDR_RESP_BACKPRESSURE_EN.
module ddr_burst_responder
  import ddr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ddr_rd,
  input  logic        ddr_wr,
  input  logic [31:0] ddr_addr,
  input  logic [7:0]  ddr_burstLength,
  input  logic [7:0]  ddr_mask,
  input  logic [63:0] ddr_din,
  output logic        ddr_waitReq,
  output logic [63:0] ddr_dout,
  output logic        ddr_valid,
  output logic        protocol_err
);

  localparam int unsigned Latency =
      (READ_LATENCY < ReadLatencyMin) ? ReadLatencyMin :
      (READ_LATENCY > ReadLatencyMax) ? ReadLatencyMax : READ_LATENCY;
  // One cycle goes to the RAM read, one to the issue register; the rest is pipe.
  localparam int unsigned PipeDepth = Latency - 2;

  ddr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  issue_active_q, issue_active_d;
  logic                  protocol_err_q, protocol_err_d;
  logic                  rd_valid_q;
  logic [63:0]           dout_q;

  logic [ADDR_WIDTH-1:0] cmd_idx, burst_idx, wr_idx, rd_idx, ram_addr;
  logic [7:0]            cmd_len;
  logic                  stall, wr_go, rd_go, ram_re;
  logic [63:0]           ram_rdata;
  logic                  unused_addr;

  assign cmd_idx     = ddr_addr[ADDR_WIDTH+2:3];
  assign cmd_len     = (ddr_burstLength == 8'd0) ? 8'd1 : ddr_burstLength;
  assign burst_idx   = base_q + ADDR_WIDTH'(beat_cnt_q);
  assign unused_addr = ^{ddr_addr[31:ADDR_WIDTH+3], ddr_addr[2:0]};

`ifdef DDR_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b11);
`else
  assign stall = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (wr_go) begin
          state_d = (cmd_len > 8'd1) ? StWriteBurst : StIdle;
        end else if (rd_go) begin
          state_d = StReadWait;
        end
      end
      StWriteBurst: begin
        if (wr_go && (beat_cnt_q == len_q - 8'd1)) begin
          state_d = StIdle;
        end
      end
      StReadWait: begin
        if (ram_re) begin
          state_d = StReadBurst;
        end
      end
      StReadBurst: begin
        // Beats are back to back, so the burst ends when the RAM stops issuing.
        if (!ram_re) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / handshake decode
  always_comb begin
    ddr_waitReq = stall;
    wr_go       = 1'b0;
    rd_go       = 1'b0;
    wr_idx      = cmd_idx;
    case (state_q)
      StIdle: begin
        wr_go = ddr_wr & ~stall;
        rd_go = ddr_rd & ~ddr_wr & ~stall;
      end
      StWriteBurst: begin
        wr_go  = ddr_wr & ~stall;
        wr_idx = burst_idx;
      end
      StReadWait, StReadBurst: begin
        ddr_waitReq = 1'b1;
      end
      default: ddr_waitReq = 1'b0;
    endcase
  end

  always_comb begin
    base_d         = base_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    issue_active_d = issue_active_q;
    protocol_err_d = protocol_err_q
                   | ((state_q == StIdle) & ddr_rd & ddr_wr)
                   | ((state_q == StWriteBurst) & ddr_rd);
    if ((state_q == StIdle) && (wr_go || rd_go)) begin
      base_d         = cmd_idx;
      len_d          = cmd_len;
      beat_cnt_d     = wr_go ? 8'd1 : 8'd0;
      issue_active_d = rd_go;
    end else if ((state_q == StWriteBurst) && wr_go) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end else if (issue_active_q) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
      if (beat_cnt_q == len_q - 8'd1) begin
        issue_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q         <= '0;
      len_q          <= 8'd1;
      beat_cnt_q     <= 8'd0;
      issue_active_q <= 1'b0;
      protocol_err_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      dout_q         <= '0;
    end else begin
      base_q         <= base_d;
      len_q          <= len_d;
      beat_cnt_q     <= beat_cnt_d;
      issue_active_q <= issue_active_d;
      protocol_err_q <= protocol_err_d;
      rd_valid_q     <= ram_re;
      if (rd_valid_q) begin
        dout_q <= ram_rdata;
      end
    end
  end

  if (PipeDepth == 0) begin : g_no_pipe
    assign ram_re = issue_active_q;
    assign rd_idx = burst_idx;
  end else begin : g_pipe
    logic [PipeDepth-1:0]  vld_q;
    logic [ADDR_WIDTH-1:0] idx_q [PipeDepth];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int i = 0; i < PipeDepth; i++) begin
          idx_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= issue_active_q;
        idx_q[0] <= burst_idx;
        for (int i = 1; i < PipeDepth; i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign ram_re = vld_q[PipeDepth-1];
    assign rd_idx = idx_q[PipeDepth-1];
  end

  // Writes never overlap reads: the read states hold waitReq high.
  assign ram_addr = wr_go ? wr_idx : rd_idx;

  ddr_byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (wr_go),
    .be_i   (ddr_mask),
    .addr_i (ram_addr),
    .wdata_i(ddr_din),
    .rdata_o(ram_rdata)
  );

  assign ddr_valid    = rd_valid_q;
  assign ddr_dout     = rd_valid_q ? ram_rdata : dout_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Directed self-checking bench for ddr_burst_responder (default build, no backpressure).
module tb_ddr_burst_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ddr_rd = 1'b0;
  logic        ddr_wr = 1'b0;
  logic [31:0] ddr_addr = '0;
  logic [7:0]  ddr_burstLength = '0;
  logic [7:0]  ddr_mask = '0;
  logic [63:0] ddr_din = '0;
  logic        ddr_waitReq;
  logic [63:0] ddr_dout;
  logic        ddr_valid;
  logic        protocol_err;

  int checks = 0;
  int failures = 0;
  logic [63:0] beat_data [16];
  logic [63:0] exp_data [16];

  ddr_burst_responder #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ddr_rd         (ddr_rd),
    .ddr_wr         (ddr_wr),
    .ddr_addr       (ddr_addr),
    .ddr_burstLength(ddr_burstLength),
    .ddr_mask       (ddr_mask),
    .ddr_din        (ddr_din),
    .ddr_waitReq    (ddr_waitReq),
    .ddr_dout       (ddr_dout),
    .ddr_valid      (ddr_valid),
    .protocol_err   (protocol_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    ddr_rd = 1'b0;
    ddr_wr = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Later beats carry junk address/length to show they are sampled only at acceptance.
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] blen,
                             input logic [7:0] mask, input int nbeats,
                             input int gap_before, input int rd_beat);
    for (int n = 0; n < nbeats; n++) begin
      if (n == gap_before) begin
        @(posedge clock); #1;
        ddr_wr = 1'b0;
        ddr_rd = 1'b0;
      end
      @(posedge clock); #1;
      ddr_wr   = 1'b1;
      ddr_rd   = (n == rd_beat);
      ddr_mask = mask;
      ddr_din  = beat_data[n];
      if (n == 0) begin
        ddr_addr        = addr;
        ddr_burstLength = blen;
      end else begin
        ddr_addr        = 32'hDEAD_BEE8;
        ddr_burstLength = 8'd1;
      end
    end
    @(posedge clock); #1;
    ddr_wr = 1'b0;
    ddr_rd = 1'b0;
    @(negedge clock);
    check_eq("wr_done_wait", ddr_waitReq, 0);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] blen, input int nbeats);
    @(posedge clock); #1;
    ddr_rd          = 1'b1;
    ddr_addr        = addr;
    ddr_burstLength = blen;
    @(negedge clock);
    check_eq("rd_accept_wait", ddr_waitReq, 0);
    @(posedge clock); #1;
    ddr_rd          = 1'b0;
    ddr_addr        = 32'hFFFF_FFF8;
    ddr_burstLength = 8'hFF;
    for (int k = 1; k <= LAT + nbeats; k++) begin
      @(negedge clock);
      if (k < LAT) begin
        check_eq("rd_valid_early", ddr_valid, 0);
        check_eq("rd_wait_latency", ddr_waitReq, 1);
      end else if (k < LAT + nbeats) begin
        check_eq("rd_valid_beat", ddr_valid, 1);
        check_eq("rd_dout_beat", ddr_dout, exp_data[k-LAT]);
        check_eq("rd_wait_burst", ddr_waitReq, 1);
      end else begin
        check_eq("rd_valid_after", ddr_valid, 0);
        check_eq("rd_wait_after", ddr_waitReq, 0);
        check_eq("rd_dout_hold", ddr_dout, exp_data[nbeats-1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_valid", ddr_valid, 0);
    check_eq("rst_wait", ddr_waitReq, 0);
    check_eq("rst_dout", ddr_dout, 0);
    check_eq("rst_err", protocol_err, 0);
    @(posedge clock); #1 reset = 1'b0;

    // Four-beat write then read at 0x40
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = 64'(i + 1);
      exp_data[i]  = 64'(i + 1);
    end
    write_burst(32'h40, 8'd4, 8'hFF, 4, -1, -1);
    read_burst(32'h40, 8'd4, 4);
    check_eq("err_clean", protocol_err, 0);

    // Partial mask over an all-ones word; length 0 writes a single beat
    beat_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(32'h0, 8'd1, 8'hFF, 1, -1, -1);
    beat_data[0] = 64'h1111_2222_3333_4444;
    write_burst(32'h0, 8'd0, 8'h0F, 1, -1, -1);
    exp_data[0] = 64'hFFFF_FFFF_3333_4444;
    read_burst(32'h0, 8'd1, 1);

    // Write wraps from word 1023 to word 0
    beat_data[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    beat_data[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    write_burst(32'h1FF8, 8'd2, 8'hFF, 2, -1, -1);
    exp_data[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    exp_data[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    read_burst(32'h1FF8, 8'd2, 2);
    exp_data[0] = 64'hBBBB_BBBB_BBBB_BBBB;
    read_burst(32'h8000_2000, 8'd1, 1);

    // Length-0 read gives exactly one beat
    exp_data[0] = 64'h1;
    read_burst(32'h40, 8'd0, 1);

    // Gap cycle inside a write burst must not consume a beat
    beat_data[0] = 64'h10;
    beat_data[1] = 64'h20;
    beat_data[2] = 64'h30;
    write_burst(32'h80, 8'd3, 8'hFF, 3, 2, -1);
    exp_data[0] = 64'h10;
    exp_data[1] = 64'h20;
    exp_data[2] = 64'h30;
    read_burst(32'h80, 8'd3, 3);
    check_eq("err_clean_gap", protocol_err, 0);

    // rd and wr together in IDLE: write wins, read ignored, error sticks
    beat_data[0] = 64'h5555;
    write_burst(32'h100, 8'd1, 8'hFF, 1, -1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_eq("rdwr_no_valid", ddr_valid, 0);
    end
    check_eq("rdwr_err", protocol_err, 1);
    exp_data[0] = 64'h5555;
    read_burst(32'h100, 8'd1, 1);
    check_eq("rdwr_err_sticky", protocol_err, 1);
    do_reset();
    @(negedge clock);
    check_eq("err_cleared", protocol_err, 0);

    // rd during WRITE_BURST flags an error but the write still completes
    beat_data[0] = 64'h3000;
    beat_data[1] = 64'h3001;
    write_burst(32'h300, 8'd2, 8'hFF, 2, -1, 1);
    check_eq("wb_rd_err", protocol_err, 1);
    exp_data[0] = 64'h3000;
    exp_data[1] = 64'h3001;
    read_burst(32'h300, 8'd2, 2);
    do_reset();

    // Reset on beat 2 of an 8-beat read
    for (int i = 0; i < 8; i++) begin
      beat_data[i] = 64'h100 + 64'(i);
      exp_data[i]  = 64'h100 + 64'(i);
    end
    write_burst(32'h200, 8'd8, 8'hFF, 8, -1, -1);
    @(posedge clock); #1;
    ddr_rd          = 1'b1;
    ddr_addr        = 32'h200;
    ddr_burstLength = 8'd8;
    @(posedge clock); #1;
    ddr_rd = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clock);
    end
    check_eq("abort_beat2_valid", ddr_valid, 1);
    check_eq("abort_beat2_dout", ddr_dout, 64'h102);
    reset = 1'b1;
    #1;
    check_eq("abort_valid", ddr_valid, 0);
    check_eq("abort_dout", ddr_dout, 0);
    check_eq("abort_wait", ddr_waitReq, 0);
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check_eq("abort_quiet", ddr_valid, 0);
    end
    read_burst(32'h200, 8'd8, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
